// File: rtl/awsf1_pcim_pkg.sv
// Shared widths, response codes and FSM state types for the PCIM responder.
// Optional stall injection in the top is enabled by defining AWSF1_PCIM_RESP_STALL_EN.
package awsf1_pcim_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    localparam int STRB_W = 64;
    localparam int USER_W = 19;

    localparam logic [2:0] BEAT_SIZE   = 3'd6;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/awsf1_pcim_mem.sv
// Byte-strobed 512-bit word memory: one write port (1-cycle), one combinational read port.
// Read-before-write: a same-cycle read of the written word returns the old contents; no backpressure.
module awsf1_pcim_mem
    import awsf1_pcim_pkg::*;
#(
    parameter int MEM_WORDS_LOG2 = 6
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [MEM_WORDS_LOG2-1:0] wr_idx,
    input  logic [STRB_W-1:0]         wr_strb,
    input  logic [DATA_W-1:0]         wr_dat,
    input  logic [MEM_WORDS_LOG2-1:0] rd_idx,
    output logic [DATA_W-1:0]         rd_dat
);

    localparam int DEPTH = 1 << MEM_WORDS_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (wr_en && wr_strb[b]) begin
                mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
            end
        end
    end

    assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/awsf1_pcim_responder.sv
// Shell-side PCIM AXI4 responder: write bursts into, read bursts from a small memory; 1-cycle turnaround per phase.
// Valids hold until handshake; AWSF1_PCIM_RESP_STALL_EN adds LFSR-driven ready gating and valid delay.
module awsf1_pcim_responder
    import awsf1_pcim_pkg::*;
#(
    parameter int MEM_WORDS_LOG2 = 6,
    parameter int ID_W           = 16
) (
    input  logic                clk_main_a0,
    input  logic                rst_main_n,

    input  logic                cl_sh_pcim_awvalid,
    input  logic [ADDR_W-1:0]   cl_sh_pcim_awaddr,
    input  logic [ID_W-1:0]     cl_sh_pcim_awid,
    input  logic [7:0]          cl_sh_pcim_awlen,
    input  logic [2:0]          cl_sh_pcim_awsize,
    input  logic [USER_W-1:0]   cl_sh_pcim_awuser,
    output logic                sh_cl_pcim_awready,

    input  logic                cl_sh_pcim_wvalid,
    input  logic [DATA_W-1:0]   cl_sh_pcim_wdata,
    input  logic [STRB_W-1:0]   cl_sh_pcim_wstrb,
    input  logic                cl_sh_pcim_wlast,
    output logic                sh_cl_pcim_wready,

    output logic                sh_cl_pcim_bvalid,
    output logic [ID_W-1:0]     sh_cl_pcim_bid,
    output logic [1:0]          sh_cl_pcim_bresp,
    input  logic                cl_sh_pcim_bready,

    input  logic                cl_sh_pcim_arvalid,
    input  logic [ADDR_W-1:0]   cl_sh_pcim_araddr,
    input  logic [ID_W-1:0]     cl_sh_pcim_arid,
    input  logic [7:0]          cl_sh_pcim_arlen,
    input  logic [2:0]          cl_sh_pcim_arsize,
    input  logic [USER_W-1:0]   cl_sh_pcim_aruser,
    output logic                sh_cl_pcim_arready,

    output logic                sh_cl_pcim_rvalid,
    output logic [DATA_W-1:0]   sh_cl_pcim_rdata,
    output logic [ID_W-1:0]     sh_cl_pcim_rid,
    output logic [1:0]          sh_cl_pcim_rresp,
    output logic                sh_cl_pcim_rlast,
    input  logic                cl_sh_pcim_rready,

    output logic [31:0]         wr_beats,
    output logic [31:0]         rd_beats
);

    localparam int IW = MEM_WORDS_LOG2;

    logic rdy_gate;
    logic vld_go;

`ifdef AWSF1_PCIM_RESP_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign rdy_gate = lfsr[0];
    assign vld_go   = lfsr[1];
`else
    assign rdy_gate = 1'b1;
    assign vld_go   = 1'b1;
`endif

    logic awready_q;
    logic wready_q;
    logic arready_q;

    assign sh_cl_pcim_awready = awready_q & rdy_gate;
    assign sh_cl_pcim_wready  = wready_q  & rdy_gate;
    assign sh_cl_pcim_arready = arready_q & rdy_gate;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic r_hs;

    assign aw_hs = cl_sh_pcim_awvalid & sh_cl_pcim_awready;
    assign w_hs  = cl_sh_pcim_wvalid  & sh_cl_pcim_wready;
    assign ar_hs = cl_sh_pcim_arvalid & sh_cl_pcim_arready;
    assign r_hs  = sh_cl_pcim_rvalid  & cl_sh_pcim_rready;

    // ---------------- write channel ----------------
    wr_state_t       wst;
    logic [ID_W-1:0] w_id;
    logic [7:0]      w_len;
    logic [7:0]      w_cnt;
    logic [IW-1:0]   w_idx;
    logic            w_err;
    logic            w_cnt_end;

    assign w_cnt_end = (w_cnt == w_len);

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            wst               <= W_IDLE;
            awready_q         <= 1'b0;
            wready_q          <= 1'b0;
            sh_cl_pcim_bvalid <= 1'b0;
            sh_cl_pcim_bid    <= '0;
            sh_cl_pcim_bresp  <= RESP_OKAY;
            w_id              <= '0;
            w_len             <= '0;
            w_cnt             <= '0;
            w_idx             <= '0;
            w_err             <= 1'b0;
            wr_beats          <= '0;
        end else begin
            case (wst)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (aw_hs) begin
                        w_id      <= cl_sh_pcim_awid;
                        w_len     <= cl_sh_pcim_awlen;
                        w_cnt     <= '0;
                        w_idx     <= cl_sh_pcim_awaddr[6 +: IW];
                        w_err     <= (cl_sh_pcim_awsize != BEAT_SIZE);
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wst       <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        w_idx    <= w_idx + 1'b1;
                        w_cnt    <= w_cnt + 8'd1;
                        wr_beats <= sat_inc(wr_beats);
                        // Either terminator ends the burst; disagreement between them is an error.
                        if (cl_sh_pcim_wlast || w_cnt_end) begin
                            wready_q          <= 1'b0;
                            sh_cl_pcim_bvalid <= vld_go;
                            sh_cl_pcim_bid    <= w_id;
                            sh_cl_pcim_bresp  <= (w_err || (cl_sh_pcim_wlast != w_cnt_end))
                                                 ? RESP_SLVERR : RESP_OKAY;
                            wst               <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (!sh_cl_pcim_bvalid) begin
                        sh_cl_pcim_bvalid <= vld_go;
                    end else if (cl_sh_pcim_bready) begin
                        sh_cl_pcim_bvalid <= 1'b0;
                        awready_q         <= 1'b1;
                        wst               <= W_IDLE;
                    end
                end
                default: wst <= W_IDLE;
            endcase
        end
    end

    // ---------------- read channel ----------------
    rd_state_t       rst;
    logic [7:0]      r_len;
    logic [7:0]      r_cnt;
    logic [IW-1:0]   r_idx;
    logic            r_err;
    logic [IW-1:0]   rd_idx;
    logic [DATA_W-1:0] rd_dat;

    // Look ahead to the word the next registered beat will present.
    always_comb begin
        rd_idx = r_idx;
        if (rst == R_IDLE) begin
            rd_idx = cl_sh_pcim_araddr[6 +: IW];
        end else if (r_hs) begin
            rd_idx = r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            rst               <= R_IDLE;
            arready_q         <= 1'b0;
            sh_cl_pcim_rvalid <= 1'b0;
            sh_cl_pcim_rdata  <= '0;
            sh_cl_pcim_rid    <= '0;
            sh_cl_pcim_rresp  <= RESP_OKAY;
            sh_cl_pcim_rlast  <= 1'b0;
            r_len             <= '0;
            r_cnt             <= '0;
            r_idx             <= '0;
            r_err             <= 1'b0;
            rd_beats          <= '0;
        end else begin
            case (rst)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        r_len             <= cl_sh_pcim_arlen;
                        r_cnt             <= '0;
                        r_idx             <= cl_sh_pcim_araddr[6 +: IW];
                        r_err             <= (cl_sh_pcim_arsize != BEAT_SIZE);
                        sh_cl_pcim_rid    <= cl_sh_pcim_arid;
                        sh_cl_pcim_rresp  <= (cl_sh_pcim_arsize != BEAT_SIZE) ? RESP_SLVERR : RESP_OKAY;
                        sh_cl_pcim_rlast  <= (cl_sh_pcim_arlen == 8'd0);
                        sh_cl_pcim_rdata  <= (cl_sh_pcim_arsize != BEAT_SIZE) ? '0 : rd_dat;
                        sh_cl_pcim_rvalid <= vld_go;
                        arready_q         <= 1'b0;
                        rst               <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (!sh_cl_pcim_rvalid) begin
                        sh_cl_pcim_rvalid <= vld_go;
                        sh_cl_pcim_rdata  <= r_err ? '0 : rd_dat;
                    end else if (cl_sh_pcim_rready) begin
                        rd_beats <= sat_inc(rd_beats);
                        if (sh_cl_pcim_rlast) begin
                            sh_cl_pcim_rvalid <= 1'b0;
                            arready_q         <= 1'b1;
                            rst               <= R_IDLE;
                        end else begin
                            r_idx             <= r_idx + 1'b1;
                            r_cnt             <= r_cnt + 8'd1;
                            sh_cl_pcim_rlast  <= ((r_cnt + 8'd1) == r_len);
                            sh_cl_pcim_rdata  <= r_err ? '0 : rd_dat;
                            sh_cl_pcim_rvalid <= vld_go;
                        end
                    end
                end
                default: rst <= R_IDLE;
            endcase
        end
    end

    awsf1_pcim_mem #(
        .MEM_WORDS_LOG2 (MEM_WORDS_LOG2)
    ) u_mem (
        .clk     (clk_main_a0),
        .wr_en   (w_hs & ~w_err),
        .wr_idx  (w_idx),
        .wr_strb (cl_sh_pcim_wstrb),
        .wr_dat  (cl_sh_pcim_wdata),
        .rd_idx  (rd_idx),
        .rd_dat  (rd_dat)
    );

    // Aliased address bits and user sideband carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{cl_sh_pcim_awaddr, cl_sh_pcim_araddr, cl_sh_pcim_awuser, cl_sh_pcim_aruser};

endmodule
